// File: rtl/deconv_overlap_accum.sv
// Overlap-add accumulator for the transposed-convolution datapath: folds per-column
// product vectors into a circular K-slot column bank and streams finished columns out.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | waiting for a product vector, o_ready high
// S_ADD  | one pixel row per cycle, K parallel adds into the bank
// S_EMIT | presenting finished columns to the consumer, lowest first
module deconv_overlap_accum #(
  parameter  int BIT_WIDTH            = 8,
  parameter  int NO_COL_KERNEL        = 5,
  parameter  int NO_COL_INPUT_FEATURE = 8,
  parameter  int STRIDE               = 2,
  parameter  int ACC_WIDTH            = 20,
  localparam int K                    = NO_COL_KERNEL,
  localparam int N                    = NO_COL_INPUT_FEATURE,
  localparam int L                    = (N - 1) * STRIDE + K,
  localparam int IW                   = $clog2(L),
  localparam int PW                   = 2 * BIT_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [PW*K*N-1:0]      i_products,
  input  logic [2:0]             i_ker_col,
  input  logic [3:0]             i_ip_col,
  output logic                   o_col_valid,
  input  logic                   i_col_ready,
  output logic [ACC_WIDTH*L-1:0] o_col_data,
  output logic [IW-1:0]          o_col_index,
  output logic                   o_done
);

  localparam int PIXW = PW * K;
  localparam int VW   = PIXW * N;
  localparam int RW   = (N > 1) ? $clog2(N) : 1;
  localparam int SW   = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_EMIT} state_t;

  state_t                state;
  logic [VW-1:0]         vec_q;
  logic [2:0]            kc_q;
  logic [3:0]            ic_q;
  logic [RW-1:0]         row_cnt;
  logic [IW-1:0]         col_ptr;
  logic [IW-1:0]         last_col;
  logic [ACC_WIDTH-1:0]  bank [K][L];

  logic [SW-1:0]         add_slot;
  logic [SW-1:0]         emit_slot;
  logic [IW-1:0]         row_base;
  logic [IW-1:0]         ic_base;

  function automatic logic [ACC_WIDTH-1:0] sext(input logic [PW-1:0] p);
    return ACC_WIDTH'($signed(p));
  endfunction

  always_comb begin
    add_slot  = SW'((int'(ic_q) * STRIDE + int'(kc_q)) % K);
    emit_slot = SW'(int'(col_ptr) % K);
    row_base  = IW'(int'(row_cnt) * STRIDE);
    ic_base   = IW'(int'(ic_q) * STRIDE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      vec_q       <= '0;
      kc_q        <= '0;
      ic_q        <= '0;
      row_cnt     <= '0;
      col_ptr     <= '0;
      last_col    <= '0;
      o_ready     <= 1'b1;
      o_col_valid <= 1'b0;
      o_done      <= 1'b0;
      for (int s = 0; s < K; s++)
        for (int j = 0; j < L; j++)
          bank[s][j] <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            vec_q   <= i_products;
            kc_q    <= i_ker_col;
            ic_q    <= i_ip_col;
            row_cnt <= '0;
            o_ready <= 1'b0;
            state   <= S_ADD;
          end
        end
        S_ADD: begin
          for (int k = 0; k < K; k++)
            bank[add_slot][row_base + IW'(k)] <= bank[add_slot][row_base + IW'(k)]
              + sext(vec_q[int'(row_cnt) * PIXW + k * PW +: PW]);
          if (row_cnt == RW'(N - 1)) begin
            if (kc_q != 3'(K - 1)) begin
              o_ready <= 1'b1;
              state   <= S_IDLE;
            end else begin
              // the last input column also finishes the K-S trailing columns
              last_col    <= (ic_q == 4'(N - 1)) ? IW'(L - 1) : ic_base + IW'(STRIDE - 1);
              o_col_valid <= 1'b1;
              state       <= S_EMIT;
            end
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        S_EMIT: begin
          if (i_col_ready) begin
            for (int j = 0; j < L; j++)
              bank[emit_slot][j] <= '0;
            if (col_ptr == last_col) begin
              o_col_valid <= 1'b0;
              o_ready     <= 1'b1;
              state       <= S_IDLE;
              if (col_ptr == IW'(L - 1)) begin
                o_done  <= 1'b1;
                col_ptr <= '0;
                ic_q    <= '0;
              end else begin
                col_ptr <= col_ptr + 1'b1;
              end
            end else begin
              col_ptr <= col_ptr + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_col_data = '0;
    if (o_col_valid)
      for (int j = 0; j < L; j++)
        o_col_data[j*ACC_WIDTH +: ACC_WIDTH] = bank[emit_slot][j];
  end

  assign o_col_index = o_col_valid ? col_ptr : '0;

endmodule

// File: tb/tb_deconv_overlap_accum.sv
// Directed bench for deconv_overlap_accum: impulse, overlap, sweep, backpressure,
// sign and mid-ADD reset, with a direct overlap-add reference for whole columns.
module tb_deconv_overlap_accum;

  localparam int BW  = 8;
  localparam int K   = 5;
  localparam int N   = 8;
  localparam int S   = 2;
  localparam int ACC = 20;
  localparam int L   = (N - 1) * S + K;
  localparam int IW  = $clog2(L);
  localparam int PW  = 2 * BW;
  localparam int VW  = PW * K * N;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_valid;
  logic             o_ready;
  logic [VW-1:0]    i_products;
  logic [2:0]       i_ker_col;
  logic [3:0]       i_ip_col;
  logic             o_col_valid;
  logic             i_col_ready;
  logic [ACC*L-1:0] o_col_data;
  logic [IW-1:0]    o_col_index;
  logic             o_done;

  deconv_overlap_accum dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_products  (i_products),
    .i_ker_col   (i_ker_col),
    .i_ip_col    (i_ip_col),
    .o_col_valid (o_col_valid),
    .i_col_ready (i_col_ready),
    .o_col_data  (o_col_data),
    .o_col_index (o_col_index),
    .o_done      (o_done)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference bank indexed [column][row]
  logic [ACC-1:0]   exp_m [L][L];
  logic [ACC*L-1:0] got_col [L];
  int               vec_at_col [L];
  int               vec_count, next_idx, order_err, n_cols, done_cnt, idle_nz;

  always @(negedge i_clk) begin
    if (o_col_valid && i_col_ready) begin
      if (int'(o_col_index) != next_idx) order_err++;
      got_col[o_col_index]    = o_col_data;
      vec_at_col[o_col_index] = vec_count;
      next_idx = (next_idx == L - 1) ? 0 : next_idx + 1;
      n_cols++;
    end
    if (!o_col_valid && (o_col_data != '0 || o_col_index != '0)) idle_nz++;
    if (o_done) done_cnt++;
  end

  function automatic logic [PW-1:0] prod(input int mode, input int ic, input int kc,
                                         input int r, input int k);
    case (mode)
      0:       return (ic == 0 && kc == 0 && r == 0) ? PW'(k + 1) : '0;
      1:       return (ic == 0 && kc == 0 && r < 2) ? PW'(1) : '0;
      2:       return PW'(1);
      default: return (ic * S + kc == 4 && r * S + k == 4) ? 16'hFFFF : '0;
    endcase
  endfunction

  function automatic logic [ACC-1:0] row_of(input logic [ACC*L-1:0] col, input int j);
    return col[j*ACC +: ACC];
  endfunction

  task automatic clear_tracking();
    for (int c = 0; c < L; c++) begin
      got_col[c] = '0;
      vec_at_col[c] = -1;
      for (int j = 0; j < L; j++) exp_m[c][j] = '0;
    end
    vec_count = 0; next_idx = 0; order_err = 0; n_cols = 0; done_cnt = 0; idle_nz = 0;
  endtask

  // entered and left at posedge+1
  task automatic send_vec(input int mode, input int ic, input int kc);
    int waitc;
    for (int r = 0; r < N; r++)
      for (int k = 0; k < K; k++)
        i_products[(r*K + k)*PW +: PW] = prod(mode, ic, kc, r, k);
    i_ip_col  = 4'(ic);
    i_ker_col = 3'(kc);
    i_valid   = 1'b1;
    waitc = 0;
    @(negedge i_clk);
    while (!o_ready && waitc < 200) begin
      @(negedge i_clk);
      waitc++;
    end
    if (!o_ready) check_val("accept_timeout", 0, 1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    vec_count++;
    for (int r = 0; r < N; r++)
      for (int k = 0; k < K; k++)
        exp_m[ic*S + kc][r*S + k] = exp_m[ic*S + kc][r*S + k]
          + ACC'($signed(prod(mode, ic, kc, r, k)));
  endtask

  task automatic backpressure();
    int waitc, lost, unstable, rdy;
    logic [ACC*L-1:0] d0;
    logic [IW-1:0]    i0;
    waitc = 0; lost = 0; unstable = 0; rdy = 0;
    @(negedge i_clk);
    while (!o_col_valid && waitc < 20) begin
      @(negedge i_clk);
      waitc++;
    end
    check_val("bp_valid_seen", o_col_valid, 1);
    d0 = o_col_data;
    i0 = o_col_index;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (!o_col_valid) lost++;
      if (o_col_data !== d0 || o_col_index !== i0) unstable++;
      if (o_ready) rdy++;
    end
    check_val("bp_valid_held", lost, 0);
    check_val("bp_stable", unstable, 0);
    check_val("bp_ready_low", rdy, 0);
    @(posedge i_clk);
    #1;
    i_col_ready = 1'b1;
  endtask

  task automatic run_channel(input string name, input int mode, input int bp_ic);
    int waitc;
    clear_tracking();
    for (int ic = 0; ic < N; ic++)
      for (int kc = 0; kc < K; kc++) begin
        if (ic == bp_ic && kc == K - 1) i_col_ready = 1'b0;
        send_vec(mode, ic, kc);
        if (ic == bp_ic && kc == K - 1) backpressure();
      end
    waitc = 0;
    while (done_cnt == 0 && waitc < 200) begin
      @(posedge i_clk);
      waitc++;
    end
    repeat (4) @(posedge i_clk);
    #1;
    for (int c = 0; c < L; c++) begin
      logic [ACC*L-1:0] e;
      for (int j = 0; j < L; j++) e[j*ACC +: ACC] = exp_m[c][j];
      check_val($sformatf("%s_col%0d", name, c), got_col[c], e);
    end
    check_val({name, "_order"}, order_err, 0);
    check_val({name, "_ncols"}, n_cols, L);
    check_val({name, "_done_once"}, done_cnt, 1);
    check_val({name, "_idle_zero"}, idle_nz, 0);
    check_val({name, "_ready_end"}, o_ready, 1);
  endtask

  logic [ACC*L-1:0] imp_col0;

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_products = '0; i_ker_col = '0; i_ip_col = '0;
    i_col_ready = 1'b1;
    clear_tracking();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check_val("rst_ready", o_ready, 1);
    check_val("rst_col_valid", o_col_valid, 0);
    check_val("rst_col_data", o_col_data, 0);
    check_val("rst_col_index", o_col_index, 0);
    check_val("rst_done", o_done, 0);

    run_channel("impulse", 0, -1);
    for (int j = 0; j < K; j++)
      check_val($sformatf("impulse_c0r%0d", j), row_of(got_col[0], j), j + 1);
    imp_col0 = got_col[0];

    run_channel("overlap", 1, -1);
    check_val("overlap_c0r0", row_of(got_col[0], 0), 1);
    check_val("overlap_c0r1", row_of(got_col[0], 1), 1);
    check_val("overlap_c0r2", row_of(got_col[0], 2), 2);
    check_val("overlap_c0r3", row_of(got_col[0], 3), 2);
    check_val("overlap_c0r4", row_of(got_col[0], 4), 2);
    check_val("overlap_c0r5", row_of(got_col[0], 5), 1);
    check_val("overlap_c0r6", row_of(got_col[0], 6), 1);

    run_channel("sweep", 2, 3);
    check_val("sweep_c0r0", row_of(got_col[0], 0), 1);
    check_val("sweep_c4r4", row_of(got_col[4], 4), 9);
    check_val("sweep_c0_after_ic0", vec_at_col[0], K);
    check_val("sweep_c1_after_ic0", vec_at_col[1], K);
    check_val("sweep_c2_after_ic1", vec_at_col[2], 2 * K);

    run_channel("sign", 3, -1);
    check_val("sign_c4r4", row_of(got_col[4], 4), 20'hFFFF7);

    // abort an impulse vector part-way through its ADD phase
    clear_tracking();
    send_vec(0, 0, 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check_val("midrst_ready", o_ready, 1);
    check_val("midrst_col_valid", o_col_valid, 0);
    run_channel("rerun", 0, -1);
    check_val("rerun_c0_same", got_col[0], imp_col0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
